// File: rtl/frame.sv
`default_nettype none
// ============================================================================
//  Module   : frame
//  Purpose  : Lab-board I/O frame. Scans a 5x4 matrix keypad, debounces and
//             accepts hex digits into a 32-bit entry buffer, and shows the
//             buffer (optionally mixed with the slide switches) on an 8-digit
//             seven-segment display fed through a serial shift chain.
//             Optional buzzer beep on each accepted key, built only when the
//             macro FRAME_BUZZER_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module frame #(
    parameter int SCAN_DIV  = 50000,
    parameter int DEBOUNCE  = 4,
    parameter int SHIFT_DIV = 8,
    parameter int BEEP_LEN  = 5000000,
    parameter int BEEP_HALF = 25000
) (
    input  logic        clk_100mhz,
    input  logic        RSTN,
    input  logic [15:0] SW,
    input  logic [3:0]  K_COL,
    output logic [4:0]  K_ROW,
    output logic        RDY,
    output logic        readn,
    output logic        CR,
    output logic        Buzzer,
    output logic        SEGCLk,
    output logic        SEGDT,
    output logic        SEGEN,
    output logic        SEGCLR
);

    localparam int c_scan_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_db_w   = $clog2(DEBOUNCE + 1);
    localparam int c_tick_w = $clog2(2 * SHIFT_DIV);

    localparam logic [c_scan_w-1:0] c_scan_last = c_scan_w'(SCAN_DIV - 1);
    localparam logic [c_db_w-1:0]   c_db        = c_db_w'(DEBOUNCE);
    localparam logic [c_tick_w-1:0] c_tick_rise = c_tick_w'(SHIFT_DIV);
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(2 * SHIFT_DIV - 1);
    localparam logic [6:0]          c_latch_bit = 7'd64;

    // Parameter sanity: the counters below assume at least one clock per step.
    if (SCAN_DIV < 1 || DEBOUNCE < 1 || SHIFT_DIV < 1 || BEEP_LEN < 1 || BEEP_HALF < 1) begin : g_bad_cfg
        $error("frame: all timing parameters must be >= 1");
    end

    // Active-low seven-segment pattern {dp,g,f,e,d,c,b,a}, decimal point off.
    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
            4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
            4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
            4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
        endcase
        return s;
    endfunction

    logic                r_segclr;
    logic [c_scan_w-1:0] r_scan_cnt;
    logic [2:0]          r_row;
    logic                r_cand_valid;
    logic [4:0]          r_cand;
    logic                r_last_valid;
    logic [4:0]          r_last_code;
    logic [c_db_w-1:0]   r_match;
    logic                r_locked;
    logic                r_consume;
    logic [4:0]          r_key;
    logic [31:0]         r_entry;
    logic [c_tick_w-1:0] r_tick;
    logic [6:0]          r_bit;
    logic [63:0]         r_shreg;
    logic                r_segdt;
    logic                r_segclk;
    logic                r_segen;

    logic [3:0]          w_col_low;
    logic                w_one_hot;
    logic [1:0]          w_col_idx;
    logic                w_slot_end;
    logic                w_scan_end;
    logic                w_res_valid;
    logic [4:0]          w_res_code;
    logic [c_db_w-1:0]   w_match_next;
    logic                w_accept;
    logic [31:0]         w_value;
    logic [63:0]         w_image;

    // Decode the sampled columns into a candidate code; several low columns is ambiguous.
    always_comb begin
        w_col_low  = ~K_COL;
        w_one_hot  = (w_col_low != 4'd0) && ((w_col_low & (w_col_low - 4'd1)) == 4'd0);
        w_col_idx  = 2'd0;
        case (w_col_low)
            4'b0010: w_col_idx = 2'd1;
            4'b0100: w_col_idx = 2'd2;
            4'b1000: w_col_idx = 2'd3;
            default: w_col_idx = 2'd0;
        endcase
        w_slot_end   = (r_scan_cnt == c_scan_last);
        w_scan_end   = w_slot_end && (r_row == 3'd4);
        // The current slot still counts when it is the last one of the scan.
        w_res_valid  = r_cand_valid || w_one_hot;
        w_res_code   = r_cand_valid ? r_cand : {r_row, w_col_idx};
        if (r_last_valid && (r_last_code == w_res_code))
            w_match_next = (r_match == c_db) ? r_match : r_match + 1'b1;
        else
            w_match_next = {{(c_db_w-1){1'b0}}, 1'b1};
        w_accept = w_scan_end && w_res_valid && !r_locked && (w_match_next == c_db);
    end

    // Row rotation, per-scan candidate capture and debounce/lockout tracking.
    always_ff @(posedge clk_100mhz) begin
        if (RSTN) begin
            r_segclr     <= 1'b0;
            r_scan_cnt   <= '0;
            r_row        <= 3'd0;
            r_cand_valid <= 1'b0;
            r_cand       <= 5'd0;
            r_last_valid <= 1'b0;
            r_last_code  <= 5'd0;
            r_match      <= '0;
            r_locked     <= 1'b0;
            r_consume    <= 1'b0;
            r_key        <= 5'd0;
        end else begin
            r_segclr  <= 1'b1;
            r_consume <= w_accept;
            if (w_accept)
                r_key <= w_res_code;
            if (!w_slot_end) begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end else begin
                r_scan_cnt <= '0;
                if (w_scan_end) begin
                    r_row        <= 3'd0;
                    r_cand_valid <= 1'b0;
                    if (!w_res_valid) begin
                        r_last_valid <= 1'b0;
                        r_match      <= '0;
                        r_locked     <= 1'b0;
                    end else begin
                        r_last_valid <= 1'b1;
                        r_last_code  <= w_res_code;
                        r_match      <= w_match_next;
                        if (w_accept)
                            r_locked <= 1'b1;
                    end
                end else begin
                    r_row <= r_row + 3'd1;
                    if (!r_cand_valid && w_one_hot) begin
                        r_cand_valid <= 1'b1;
                        r_cand       <= {r_row, w_col_idx};
                    end
                end
            end
        end
    end

    // Entry buffer: apply the accepted key at the end of the consume cycle.
    always_ff @(posedge clk_100mhz) begin
        if (RSTN) begin
            r_entry <= 32'd0;
        end else if (r_consume) begin
            if (!r_key[4])
                r_entry <= {r_entry[27:0], r_key[3:0]};
            else if (r_key == 5'd16)
                r_entry <= 32'd0;
            else if (r_key == 5'd17)
                r_entry <= r_entry >> 4;
        end
    end

    // Display value and its 64-bit segment image, digit 7 in the top byte.
    always_comb begin
        w_value = SW[0] ? {SW, r_entry[15:0]} : r_entry;
        w_image = '0;
        for (int i = 0; i < 8; i++)
            w_image[63 - 8*i -: 8] = seg7(w_value[31 - 4*i -: 4]);
    end

    // Serial frame: 64 data slots then one latch slot, each 2*SHIFT_DIV clocks.
    // Data moves only at slot start, while the shift clock is low.
    always_ff @(posedge clk_100mhz) begin
        if (RSTN) begin
            r_tick   <= '0;
            r_bit    <= 7'd0;
            r_shreg  <= 64'd0;
            r_segdt  <= 1'b0;
            r_segclk <= 1'b0;
            r_segen  <= 1'b0;
        end else begin
            if (r_tick == '0) begin
                r_segclk <= 1'b0;
                if (r_bit == 7'd0) begin
                    r_segdt <= w_image[63];
                    r_shreg <= {w_image[62:0], 1'b0};
                    r_segen <= 1'b0;
                end else if (r_bit == c_latch_bit) begin
                    r_segen <= 1'b1;
                end else begin
                    r_segdt <= r_shreg[63];
                    r_shreg <= {r_shreg[62:0], 1'b0};
                end
            end else if ((r_tick == c_tick_rise) && (r_bit != c_latch_bit)) begin
                r_segclk <= 1'b1;
            end
            if (r_tick == c_tick_last) begin
                r_tick <= '0;
                r_bit  <= (r_bit == c_latch_bit) ? 7'd0 : r_bit + 7'd1;
            end else begin
                r_tick <= r_tick + 1'b1;
            end
        end
    end

`ifdef FRAME_BUZZER_EN
    localparam int c_bl_w = $clog2(BEEP_LEN + 1);
    localparam int c_bh_w = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;
    localparam logic [c_bl_w-1:0] c_beep_len  = c_bl_w'(BEEP_LEN);
    localparam logic [c_bh_w-1:0] c_beep_half = c_bh_w'(BEEP_HALF - 1);

    logic [c_bl_w-1:0] r_beep_left;
    logic [c_bh_w-1:0] r_tone;
    logic              r_buzz;

    // Beep: starts high in the consume cycle, restarts on every new acceptance.
    always_ff @(posedge clk_100mhz) begin
        if (RSTN) begin
            r_beep_left <= '0;
            r_tone      <= '0;
            r_buzz      <= 1'b0;
        end else if (w_accept) begin
            r_beep_left <= c_beep_len;
            r_tone      <= '0;
            r_buzz      <= 1'b1;
        end else if (r_beep_left != '0) begin
            r_beep_left <= r_beep_left - 1'b1;
            if (r_beep_left == {{(c_bl_w-1){1'b0}}, 1'b1}) begin
                r_buzz <= 1'b0;
            end else if (r_tone == c_beep_half) begin
                r_tone <= '0;
                r_buzz <= ~r_buzz;
            end else begin
                r_tone <= r_tone + 1'b1;
            end
        end
    end

    assign Buzzer = r_buzz;
`else
    assign Buzzer = 1'b0;
`endif

    assign K_ROW  = ~(5'b00001 << r_row);
    assign RDY    = r_consume;
    assign readn  = ~r_consume;
    assign CR     = r_consume && (r_key == 5'd16);
    assign SEGCLk = r_segclk;
    assign SEGDT  = r_segdt;
    assign SEGEN  = r_segen;
    assign SEGCLR = r_segclr;

endmodule
`default_nettype wire

// File: tb/tb_frame.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame
//  Purpose  : Directed self-checking bench for frame: reset values, keypad
//             entry (digits, clear, backspace, ignored codes, ambiguous
//             columns), strobe latency, display frames and buzzer beeps.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_frame;

    logic        clk_100mhz = 1'b0;
    logic        RSTN;
    logic [15:0] SW;
    logic [3:0]  K_COL;
    logic [4:0]  K_ROW;
    logic        RDY, readn, CR, Buzzer, SEGCLk, SEGDT, SEGEN, SEGCLR;

    int          key_row;
    logic [3:0]  key_mask;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk_100mhz = ~clk_100mhz;

    // Keypad model: pressed columns pull low only while their row is driven.
    always_comb K_COL = (key_mask != 4'h0 && K_ROW[key_row] == 1'b0) ? ~key_mask : 4'hF;

    frame #(
        .SCAN_DIV (4),
        .DEBOUNCE (2),
        .SHIFT_DIV(2),
        .BEEP_LEN (20),
        .BEEP_HALF(2)
    ) dut (
        .clk_100mhz(clk_100mhz),
        .RSTN      (RSTN),
        .SW        (SW),
        .K_COL     (K_COL),
        .K_ROW     (K_ROW),
        .RDY       (RDY),
        .readn     (readn),
        .CR        (CR),
        .Buzzer    (Buzzer),
        .SEGCLk    (SEGCLk),
        .SEGDT     (SEGDT),
        .SEGEN     (SEGEN),
        .SEGCLR    (SEGCLR)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Buzzer level in the 24 cycles starting at the consume cycle.
    function automatic logic [23:0] beep_pattern();
        logic [23:0] p;
        p = 24'd0;
`ifdef FRAME_BUZZER_EN
        for (int k = 0; k < 20; k++)
            p[k] = ((k / 2) % 2 == 0);
`endif
        return p;
    endfunction

    // Press a key at the start of a scan, hold 5 scans, release for 3 scans.
    task automatic press(input string tag, input int row, input logic [3:0] mask,
                         input int exp_pulses, input logic exp_cr);
        logic [4:0]  prev_row;
        logic [23:0] buzz;
        logic        cr_seen, readn_seen, row_seen;
        int          wait_n, pulses, first, cr_stray, readn_bad;
        prev_row = K_ROW;
        wait_n   = 0;
        forever begin
            @(negedge clk_100mhz);
            wait_n++;
            if ((K_ROW == 5'b11110 && prev_row == 5'b01111) || wait_n > 100) break;
            prev_row = K_ROW;
        end
        check_val({tag, "_sync"}, 64'(wait_n <= 100), 64'd1);
        key_row  = row;
        key_mask = mask;
        pulses = 0; first = -1; buzz = 24'd0; cr_stray = 0; readn_bad = 0;
        cr_seen = 1'b0; readn_seen = 1'b1; row_seen = 1'b0;
        for (int k = 1; k <= 160; k++) begin
            @(negedge clk_100mhz);
            if (readn !== ~RDY) readn_bad++;
            if (RDY) begin
                pulses++;
                if (first < 0) begin
                    first      = k;
                    cr_seen    = CR;
                    readn_seen = readn;
                    row_seen   = (K_ROW == 5'b11110);
                end
            end else if (CR) begin
                cr_stray++;
            end
            if (first >= 0 && k - first < 24) buzz[k - first] = Buzzer;
            if (k == 100) key_mask = 4'h0;
        end
        check_val({tag, "_pulses"}, 64'(pulses), 64'(exp_pulses));
        check_val({tag, "_cr_stray"}, 64'(cr_stray), 64'd0);
        check_val({tag, "_readn"}, 64'(readn_bad), 64'd0);
        if (exp_pulses > 0) begin
            check_val({tag, "_latency"}, 64'(first), 64'd40);
            check_val({tag, "_cr"}, 64'(cr_seen), 64'(exp_cr));
            check_val({tag, "_readn_low"}, 64'(readn_seen), 64'd0);
            check_val({tag, "_scan_edge"}, 64'(row_seen), 64'd1);
            check_val({tag, "_buzzer"}, 64'(buzz), 64'(beep_pattern()));
        end
    endtask

    // Capture one display frame; optionally change SW 20 cycles into it.
    task automatic capture(input string tag, input logic sync, input logic [63:0] exp,
                           input logic sw_apply, input logic [15:0] sw_new);
        logic        prev_en, prev_clk, prev_dt;
        logic [63:0] fr;
        int          w, n, viol, cyc, en_len, en_clk;
        if (sync) begin
            prev_en = SEGEN;
            w = 0;
            forever begin
                @(negedge clk_100mhz);
                w++;
                if ((prev_en && !SEGEN) || w > 600) break;
                prev_en = SEGEN;
            end
            check_val({tag, "_start"}, 64'(w <= 600), 64'd1);
        end
        prev_clk = SEGCLk; prev_dt = SEGDT;
        fr = 64'd0; n = 0; viol = 0; cyc = 0;
        forever begin
            @(negedge clk_100mhz);
            cyc++;
            if (SEGEN || cyc > 600) break;
            if (SEGCLk && !prev_clk) begin
                fr = {fr[62:0], SEGDT};
                n++;
            end
            if (SEGDT != prev_dt && SEGCLk) viol++;
            prev_clk = SEGCLk;
            prev_dt  = SEGDT;
            if (sw_apply && cyc == 20) SW = sw_new;
        end
        en_len = 1;
        en_clk = SEGCLk ? 1 : 0;
        forever begin
            @(negedge clk_100mhz);
            if (!SEGEN || en_len > 600) break;
            en_len++;
            if (SEGCLk) en_clk++;
        end
        check_val({tag, "_bits"}, 64'(n), 64'd64);
        check_val({tag, "_setup"}, 64'(viol), 64'd0);
        check_val({tag, "_shift_len"}, 64'(cyc), 64'd256);
        check_val({tag, "_segen_len"}, 64'(en_len), 64'd4);
        check_val({tag, "_segen_clk"}, 64'(en_clk), 64'd0);
        check_val({tag, "_data"}, fr, exp);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, n_errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        RSTN = 1'b1; SW = 16'h0000; key_row = 0; key_mask = 4'h0;
        repeat (3) @(posedge clk_100mhz);
        @(negedge clk_100mhz);
        check_val("rst_krow",   64'(K_ROW),  64'h1E);
        check_val("rst_rdy",    64'(RDY),    64'd0);
        check_val("rst_readn",  64'(readn),  64'd1);
        check_val("rst_cr",     64'(CR),     64'd0);
        check_val("rst_buzzer", 64'(Buzzer), 64'd0);
        check_val("rst_segclk", 64'(SEGCLk), 64'd0);
        check_val("rst_segdt",  64'(SEGDT),  64'd0);
        check_val("rst_segen",  64'(SEGEN),  64'd0);
        check_val("rst_segclr", 64'(SEGCLR), 64'd0);
        RSTN = 1'b0;
        @(negedge clk_100mhz);
        check_val("segclr_rise", 64'(SEGCLR), 64'd1);

        capture("frame_zero", 1'b1, 64'hC0C0C0C0C0C0C0C0, 1'b0, 16'h0);

        press("key8", 2, 4'b0001, 1, 1'b0);
        capture("frame_8", 1'b1, 64'hC0C0C0C0C0C0C080, 1'b0, 16'h0);

        press("key16_clr", 4, 4'b0001, 1, 1'b1);
        capture("frame_clr", 1'b1, 64'hC0C0C0C0C0C0C0C0, 1'b0, 16'h0);

        press("key1", 0, 4'b0010, 1, 1'b0);
        press("key2", 0, 4'b0100, 1, 1'b0);
        capture("frame_12", 1'b1, 64'hC0C0C0C0C0C0F9A4, 1'b1, 16'hA001);
        capture("frame_sw", 1'b0, 64'h88C0C0F9C0C0F9A4, 1'b0, 16'h0);
        SW = 16'h0000;

        press("key17_bksp", 4, 4'b0010, 1, 1'b0);
        capture("frame_1", 1'b1, 64'hC0C0C0C0C0C0C0F9, 1'b0, 16'h0);

        press("keyA", 2, 4'b0100, 1, 1'b0);
        press("keyF", 3, 4'b1000, 1, 1'b0);
        press("key18", 4, 4'b0100, 1, 1'b0);
        capture("frame_1af", 1'b1, 64'hC0C0C0C0C0F9888E, 1'b0, 16'h0);

        press("multi_col", 1, 4'b0011, 0, 1'b0);
        press("key16_again", 4, 4'b0001, 1, 1'b1);
        capture("frame_clr2", 1'b1, 64'hC0C0C0C0C0C0C0C0, 1'b0, 16'h0);

        @(negedge clk_100mhz);
        RSTN = 1'b1;
        @(negedge clk_100mhz);
        check_val("rerst_segclr", 64'(SEGCLR), 64'd0);
        check_val("rerst_krow",   64'(K_ROW),  64'h1E);
        check_val("rerst_segen",  64'(SEGEN),  64'd0);
        RSTN = 1'b0;
        @(negedge clk_100mhz);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
